// File: rtl/lsu_pkg.sv
// Shared types and size codes for the load/store unit and its alignment checker.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    localparam logic [1:0] MEM_RSVD = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_WORD = 2'b11;

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality check of a request: reserved size code and natural alignment.
module lsu_align_check
    import lsu_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       size_err,
    output logic       misaligned
);

    always_comb begin
        size_err   = (size == MEM_RSVD);
        misaligned = ((size == MEM_HALF) && addr_lo[0]) ||
                     ((size == MEM_WORD) && (addr_lo != 2'b00));
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator toward a word-indexed data memory.
// Optional build macro MISALIGN_TRAP_EN refuses misaligned half/word accesses.
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_IDX_W = 6,
    parameter int TAG_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              signed_unsigned,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_err
);

    import lsu_pkg::*;

    lsu_state_e state_q, state_d;

    logic [MEM_IDX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [1:0]           size_q, size_d;
    logic                 unsigned_q, unsigned_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 is_store_q, is_store_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    resp_data_q, resp_data_d;

    logic accept;
    logic size_err;
    logic misaligned;
    logic req_err;

    // Upper address bits only select aliases of the same word; the index wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[ADDR_W-1:MEM_IDX_W+2];

    lsu_align_check u_align (
        .size       (req_size),
        .addr_lo    (req_addr[1:0]),
        .size_err   (size_err),
        .misaligned (misaligned)
    );

`ifdef MISALIGN_TRAP_EN
    assign req_err = size_err | misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign req_err = size_err;
`endif

    assign accept = req_valid && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_err ? RESP : ISSUE;
            ISSUE:   state_d = is_store_q ? RESP : CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and handshakes decode the state flops only, so they fall with async reset.
    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_read   = (state_q == ISSUE) && !is_store_q;
        mem_write  = (state_q == ISSUE) && is_store_q;
        resp_valid = (state_q == RESP);
    end

    // Request capture; resp_data starts at zero so stores and refused accesses return 0.
    always_comb begin
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        tag_d       = tag_q;
        is_store_d  = is_store_q;
        err_d       = err_q;
        resp_data_d = resp_data_q;
        if (accept) begin
            idx_d       = req_addr[MEM_IDX_W+1:2];
            wdata_d     = req_wdata;
            size_d      = req_size;
            unsigned_d  = req_unsigned;
            tag_d       = req_tag;
            is_store_d  = req_is_store;
            err_d       = req_err;
            resp_data_d = '0;
        end else if (state_q == CAPTURE) begin
            resp_data_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            tag_q       <= '0;
            is_store_q  <= 1'b0;
            err_q       <= 1'b0;
            resp_data_q <= '0;
        end else begin
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            tag_q       <= tag_d;
            is_store_q  <= is_store_d;
            err_q       <= err_d;
            resp_data_q <= resp_data_d;
        end
    end

    // The memory has no unsigned-word code, so word loads always report signed.
    always_comb begin
        mem_addr        = {{(ADDR_W-MEM_IDX_W){1'b0}}, idx_q};
        mem_wdata       = wdata_q;
        mem_size        = size_q;
        signed_unsigned = unsigned_q && !is_store_q && (size_q != MEM_WORD);
        resp_data       = resp_data_q;
        resp_tag        = tag_q;
        resp_err        = err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a 64-word data memory and a request-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [4:0]  req_tag = '0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic        signed_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] env_mem [64];
    logic [31:0] ref_mem [64];

    load_store_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_tag         (req_tag),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .signed_unsigned (signed_unsigned),
        .mem_size        (mem_size),
        .mem_rdata       (mem_rdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_tag        (resp_tag),
        .resp_err        (resp_err)
    );

    always #5 clk = ~clk;

    // Data memory: word-indexed, registered read, does its own sign/zero extension.
    always @(posedge clk) begin
        if (mem_write) begin
            case (mem_size)
                2'b01:   env_mem[mem_addr[5:0]][7:0]  <= mem_wdata[7:0];
                2'b10:   env_mem[mem_addr[5:0]][15:0] <= mem_wdata[15:0];
                default: env_mem[mem_addr[5:0]]       <= mem_wdata;
            endcase
        end
        if (mem_read) begin
            case (mem_size)
                2'b01:   mem_rdata <= signed_unsigned ? {24'h0, env_mem[mem_addr[5:0]][7:0]}
                                                      : {{24{env_mem[mem_addr[5:0]][7]}}, env_mem[mem_addr[5:0]][7:0]};
                2'b10:   mem_rdata <= signed_unsigned ? {16'h0, env_mem[mem_addr[5:0]][15:0]}
                                                      : {{16{env_mem[mem_addr[5:0]][15]}}, env_mem[mem_addr[5:0]][15:0]};
                default: mem_rdata <= env_mem[mem_addr[5:0]];
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz, input logic un);
        int v;
        if (sz == 2'b01) v = un ? int'(w & 32'hFF) : int'(w << 24) >>> 24;
        else if (sz == 2'b10) v = un ? int'(w & 32'hFFFF) : int'(w << 16) >>> 16;
        else v = int'(w);
        return 32'(v);
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        logic e;
        e = (sz == 2'b00);
`ifdef MISALIGN_TRAP_EN
        if (sz == 2'b10 && (a % 2) != 0) e = 1'b1;
        if (sz == 2'b11 && (a % 4) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic do_req(input logic st, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic un, input logic [4:0] tg, input int hold);
        logic        e;
        int          idx;
        int          lat;
        int          nrd;
        int          nwr;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_su;
        e       = ref_err(sz, a);
        idx     = int'((a / 4) % 64);
        exp_lat = e ? 1 : (st ? 2 : 3);
        exp_su  = un && !st && (sz != 2'b11);
        exp_data = (e || st) ? 32'h0 : ref_load(ref_mem[idx], sz, un);
        if (st && !e) begin
            if (sz == 2'b01) ref_mem[idx] = (ref_mem[idx] & 32'hFFFFFF00) | (d & 32'hFF);
            else if (sz == 2'b10) ref_mem[idx] = (ref_mem[idx] & 32'hFFFF0000) | (d & 32'hFFFF);
            else ref_mem[idx] = d;
        end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_is_store = st; req_addr = a; req_wdata = d;
        req_size = sz; req_unsigned = un; req_tag = tg;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom_range(0, 3)); req_tag = 5'($urandom_range(0, 31));
        req_is_store = 1'($urandom_range(0, 1)); req_unsigned = 1'($urandom_range(0, 1));
        lat = 0; nrd = 0; nwr = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_read) begin
                nrd++;
                check("rd_addr", mem_addr, 32'(idx));
                check("rd_size", mem_size, sz);
                check("rd_su", signed_unsigned, exp_su);
            end
            if (mem_write) begin
                nwr++;
                check("wr_addr", mem_addr, 32'(idx));
                check("wr_data", mem_wdata, d);
                check("wr_size", mem_size, sz);
                check("wr_su", signed_unsigned, 0);
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, exp_lat);
        check("n_read", nrd, (!e && !st) ? 1 : 0);
        check("n_write", nwr, (!e && st) ? 1 : 0);
        if (lat == 0) return;
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            check("resp_valid", resp_valid, 1);
            check("resp_data", resp_data, exp_data);
            check("resp_tag", resp_tag, tg);
            check("resp_err", resp_err, e);
            check("req_ready_busy", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("resp_drop", resp_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 5'd1, 0);
        do_req(1'b1, 32'h14, 32'h000000F0, 2'b01, 1'b0, 5'd2, 0);
        do_req(1'b0, 32'h14, 32'h0, 2'b01, 1'b0, 5'd3, 0);
        do_req(1'b0, 32'h14, 32'h0, 2'b01, 1'b1, 5'd4, 0);
        do_req(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, 5'd5, 0);
        do_req(1'b1, 32'h20, 32'h12345678, 2'b00, 1'b0, 5'd6, 0);
        do_req(1'b0, 32'h12, 32'h0, 2'b11, 1'b0, 5'd7, 0);
        do_req(1'b0, 32'h10, 32'h0, 2'b11, 1'b1, 5'd8, 0);
        do_req(1'b0, 32'hFFFFFF10, 32'h0, 2'b10, 1'b0, 5'd9, 0);
        do_req(1'b1, 32'h24, 32'hCAFE8001, 2'b10, 1'b0, 5'd10, 5);
        do_req(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, 5'd11, 5);

        for (int n = 0; n < 80; n++) begin
            do_req(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        // Reset while a load is in ISSUE: strobe must fall without waiting for a clock.
        check("pre_rst_idle", req_ready, 1);
        req_valid = 1'b1; req_is_store = 1'b0; req_addr = 32'h10; req_size = 2'b11; req_tag = 5'd31;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("issue_read", mem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_read", mem_read, 0);
        check("rst_async_write", mem_write, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", resp_valid, 0);
            check("post_rst_no_read", mem_read, 0);
        end
        check("post_rst_ready", req_ready, 1);
        check("post_rst_data", resp_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
